// File: rtl/scope_pkg.sv
// Shared types and defaults for the triggered scope frame capture block.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        ARMED,
        POST,
        READY
    } state_t;

    localparam int SAMPLE_W      = 16;
    localparam int POINT_NUM_DEF = 400;
    localparam int PRE_NUM_DEF   = 100;
    localparam int DATA_NUM_DEF  = POINT_NUM_DEF * 2;

    // (a - b) mod n for addresses already inside 0..n-1, with b <= n-1.
    function automatic int wrap_sub(input int a, input int b, input int n);
        return (a >= b) ? (a - b) : (a + n - b);
    endfunction

endpackage

// File: rtl/scope_frame_capture_if.sv
// Sample stream in, SPI byte stream out: the two data paths of the capture block.
interface scope_frame_capture_if;
    import scope_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                fifo_rd_flag;
    logic [7:0]          spi_data;
    logic                frame_ready;

    modport master (
        output sample_in, sample_valid, fifo_rd_flag,
        input  spi_data, frame_ready
    );

    modport slave (
        input  sample_in, sample_valid, fifo_rd_flag,
        output spi_data, frame_ready
    );
endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port frame memory with a registered read port; the array is not reset.
module scope_sample_ram
    import scope_pkg::*;
#(
    parameter int DEPTH  = POINT_NUM_DEF,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);
    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/scope_frame_capture.sv
// Triggered frame acquisition with pre-trigger history, served as a high-byte-first
// byte stream to the SPI slave; re-arms by returning to IDLE after the last byte.
module scope_frame_capture
    import scope_pkg::*;
#(
    parameter int POINT_NUM    = POINT_NUM_DEF,
    parameter int DATA_NUM     = POINT_NUM * (DATA_NUM_DEF / POINT_NUM_DEF),
    parameter int PRE_NUM      = PRE_NUM_DEF,
    parameter int AUTO_TIMEOUT = 50000,
    parameter int ADDR_W       = 9
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    scope_frame_capture_if.slave  bus,
    input  logic [SAMPLE_W-1:0]   trig_level,
    input  logic                  trig_auto,
    input  logic                  arm,
    output logic                  rd_underflow,
    output logic                  trig_forced
);
    localparam int TO_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam int CNT_W = $clog2(DATA_NUM + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(POINT_NUM - 1);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POINT_NUM - PRE_NUM - 1);

    state_t               state;
    logic [ADDR_W-1:0]    wp, fill_cnt, post_cnt, rd_ptr;
    logic [TO_W-1:0]      to_cnt;
    logic [CNT_W-1:0]     rd_cnt;
    logic                 byte_sel;
    logic [SAMPLE_W-1:0]  prev;
    logic [SAMPLE_W-1:0]  rd_data;
    logic [7:0]           spi_byte;
    logic                 ready;

    logic                 take, edge_hit, timeout_hit;
    logic [ADDR_W-1:0]    wp_next, rd_next, start_addr;

    assign take        = bus.sample_valid && !arm &&
                         (state == PREFILL || state == ARMED || state == POST);
    assign edge_hit    = (prev < trig_level) && (bus.sample_in >= trig_level);
    assign timeout_hit = trig_auto && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
    assign wp_next     = (wp == LAST_ADDR) ? '0 : wp + 1'b1;
    assign rd_next     = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
    assign start_addr  = ADDR_W'(wrap_sub(int'(wp), PRE_NUM, POINT_NUM));

    assign bus.spi_data    = spi_byte;
    assign bus.frame_ready = ready;

    scope_sample_ram #(.DEPTH(POINT_NUM), .ADDR_W(ADDR_W)) u_ram (
        .clk     (sys_clk),
        .wr_en   (take),
        .wr_addr (wp),
        .wr_data (bus.sample_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            wp           <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            rd_ptr       <= '0;
            to_cnt       <= '0;
            rd_cnt       <= '0;
            byte_sel     <= 1'b1;
            prev         <= '0;
            spi_byte     <= '0;
            ready        <= 1'b0;
            rd_underflow <= 1'b0;
            trig_forced  <= 1'b0;
        end else if (arm && state != READY) begin
            state        <= (PRE_NUM == 0) ? ARMED : PREFILL;
            wp           <= '0;
            fill_cnt     <= '0;
            to_cnt       <= '0;
            prev         <= '0;
            rd_underflow <= 1'b0;
            trig_forced  <= 1'b0;
        end else begin
            if (bus.fifo_rd_flag && state != READY) rd_underflow <= 1'b1;
            if (take) wp <= wp_next;
            if (take && state != POST) prev <= bus.sample_in;

            case (state)
                PREFILL: if (take) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == ADDR_W'(PRE_NUM - 1)) state <= ARMED;
                end
                ARMED: if (take) begin
                    to_cnt <= to_cnt + 1'b1;
                    if (edge_hit || timeout_hit) begin
                        // rd_ptr only matters in READY, so the frame start is parked there now.
                        rd_ptr      <= start_addr;
                        post_cnt    <= POST_INIT;
                        trig_forced <= !edge_hit;
                        byte_sel    <= 1'b1;
                        rd_cnt      <= '0;
                        state       <= (POST_INIT == '0) ? READY : POST;
                    end
                end
                POST: if (take) begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == ADDR_W'(1)) state <= READY;
                end
                READY: begin
                    // One cycle in READY lets the registered RAM read land before ready rises.
                    ready <= 1'b1;
                    if (bus.fifo_rd_flag) begin
                        spi_byte <= byte_sel ? rd_data[15:8] : rd_data[7:0];
                        byte_sel <= !byte_sel;
                        if (!byte_sel) rd_ptr <= rd_next;
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == CNT_W'(DATA_NUM - 1)) begin
                            state <= IDLE;
                            ready <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
